// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
// Passive checker on the red/yellow/green lamp levels of the traffic-light
// controller. Decodes the lamps into a phase, measures dwell per phase and
// flags illegal lamp combinations, wrong phase order and wrong dwell times.
// All outputs are registered: a response appears one clock after the sample.
// Optional feature: define TLMON_AUTORECOVER_EN to let a red-only sample
// pull the FSM out of ERROR back into RED (error flag and code stay sticky).
module traffic_light_monitor #(
    parameter int RED_CYCLES    = 5,
    parameter int GREEN_CYCLES  = 4,
    parameter int YELLOW_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_red,
    input  logic             i_yellow,
    input  logic             i_green,
    input  logic             i_clear,
    output logic [2:0]       o_phase,
    output logic [CNT_W-1:0] o_dwell,
    output logic             o_err,
    output logic [2:0]       o_err_code,
    output logic             o_cycle_done,
    output logic [15:0]      o_cycle_cnt,
    output logic             o_abort
);

    // Phase encoding doubles as the o_phase output value.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RED    = 3'd1,
        ST_GREEN  = 3'd2,
        ST_YELLOW = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    // Colour codes share values with the matching running phases.
    typedef enum logic [2:0] {
        LAMP_OFF     = 3'd0,
        LAMP_RED     = 3'd1,
        LAMP_GREEN   = 3'd2,
        LAMP_YELLOW  = 3'd3,
        LAMP_ILLEGAL = 3'd4
    } lamp_t;

    localparam logic [2:0] CODE_NONE    = 3'd0;
    localparam logic [2:0] CODE_ILLEGAL = 3'd1;
    localparam logic [2:0] CODE_ORDER   = 3'd2;
    localparam logic [2:0] CODE_SHORT   = 3'd3;
    localparam logic [2:0] CODE_LONG    = 3'd4;

    localparam logic [CNT_W-1:0] RED_EXP    = CNT_W'(RED_CYCLES);
    localparam logic [CNT_W-1:0] GREEN_EXP  = CNT_W'(GREEN_CYCLES);
    localparam logic [CNT_W-1:0] YELLOW_EXP = CNT_W'(YELLOW_CYCLES);
    localparam logic [CNT_W-1:0] DWELL_ONE  = CNT_W'(1);

    state_t           state, state_n;
    lamp_t            lamp;
    logic [CNT_W-1:0] dwell, dwell_n;
    logic             err, err_n;
    logic [2:0]       code, code_n;
    logic             done, done_n;
    logic [15:0]      cnt, cnt_n;
    logic             abort, abort_n;
    logic [2:0]       cause;
    logic [CNT_W-1:0] exp_dwell;
    state_t           succ;

    // Lamp colour expected while sitting in a running phase.
    function automatic lamp_t lamp_of(input state_t s);
        case (s)
            ST_RED:    lamp_of = LAMP_RED;
            ST_GREEN:  lamp_of = LAMP_GREEN;
            ST_YELLOW: lamp_of = LAMP_YELLOW;
            default:   lamp_of = LAMP_OFF;
        endcase
    endfunction

    // Decode the three lamp levels into one colour, OFF or ILLEGAL.
    always_comb begin
        lamp = LAMP_ILLEGAL;
        case ({i_red, i_green, i_yellow})
            3'b000:  lamp = LAMP_OFF;
            3'b100:  lamp = LAMP_RED;
            3'b010:  lamp = LAMP_GREEN;
            3'b001:  lamp = LAMP_YELLOW;
            default: lamp = LAMP_ILLEGAL;
        endcase
    end

    // Expected dwell and legal successor of the current running phase.
    always_comb begin
        exp_dwell = RED_EXP;
        succ      = ST_GREEN;
        case (state)
            ST_GREEN: begin
                exp_dwell = GREEN_EXP;
                succ      = ST_YELLOW;
            end
            ST_YELLOW: begin
                exp_dwell = YELLOW_EXP;
                succ      = ST_RED;
            end
            default: begin
                exp_dwell = RED_EXP;
                succ      = ST_GREEN;
            end
        endcase
    end

    // Next-state, dwell, error latching and cycle bookkeeping.
    always_comb begin
        state_n = state;
        dwell_n = dwell;
        err_n   = err;
        code_n  = code;
        done_n  = 1'b0;
        cnt_n   = cnt;
        abort_n = 1'b0;
        cause   = CODE_NONE;

        if (i_clear) begin
            // Clear beats any error raised on the same sample.
            state_n = ST_IDLE;
            dwell_n = '0;
            err_n   = 1'b0;
            code_n  = CODE_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    case (lamp)
                        LAMP_OFF:     dwell_n = '0;
                        LAMP_RED: begin
                            state_n = ST_RED;
                            dwell_n = DWELL_ONE;
                        end
                        LAMP_ILLEGAL: cause = CODE_ILLEGAL;
                        default:      cause = CODE_ORDER;
                    endcase
                end
                ST_RED, ST_GREEN, ST_YELLOW: begin
                    if (lamp == LAMP_ILLEGAL) begin
                        cause = CODE_ILLEGAL;
                    end else if (lamp == LAMP_OFF) begin
                        // Controller went dark: treat as its reset, not a fault.
                        state_n = ST_IDLE;
                        dwell_n = '0;
                        abort_n = 1'b1;
                    end else if (lamp == lamp_of(state)) begin
                        // Long dwell is caught the moment it overruns.
                        if (dwell >= exp_dwell) cause = CODE_LONG;
                        else                    dwell_n = dwell + DWELL_ONE;
                    end else if (lamp == lamp_of(succ)) begin
                        if (dwell < exp_dwell) begin
                            cause = CODE_SHORT;
                        end else begin
                            state_n = succ;
                            dwell_n = DWELL_ONE;
                            if (state == ST_YELLOW) begin
                                done_n = 1'b1;
                                if (cnt != 16'hFFFF) cnt_n = cnt + 16'd1;
                            end
                        end
                    end else begin
                        cause = CODE_ORDER;
                    end
                end
                ST_ERROR: begin
`ifdef TLMON_AUTORECOVER_EN
                    if (lamp == LAMP_RED) begin
                        state_n = ST_RED;
                        dwell_n = DWELL_ONE;
                    end
`endif
                end
                default: begin
                    state_n = ST_IDLE;
                    dwell_n = '0;
                end
            endcase

            if (cause != CODE_NONE) begin
                // Dwell freezes; only the first cause is kept while err is set.
                state_n = ST_ERROR;
                dwell_n = dwell;
                err_n   = 1'b1;
                if (!err) code_n = cause;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= ST_IDLE;
            dwell <= '0;
            err   <= 1'b0;
            code  <= CODE_NONE;
            done  <= 1'b0;
            cnt   <= '0;
            abort <= 1'b0;
        end else begin
            state <= state_n;
            dwell <= dwell_n;
            err   <= err_n;
            code  <= code_n;
            done  <= done_n;
            cnt   <= cnt_n;
            abort <= abort_n;
        end
    end

    assign o_phase      = state;
    assign o_dwell      = dwell;
    assign o_err        = err;
    assign o_err_code   = code;
    assign o_cycle_done = done;
    assign o_cycle_cnt  = cnt;
    assign o_abort      = abort;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Testbench for traffic_light_monitor: fixed vector table, hand-written
// multi-cycle sequences and randomized lamp traffic against a reference model.
module tb_traffic_light_monitor;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             red = 1'b0, yellow = 1'b0, green = 1'b0, clr = 1'b0;
    logic [2:0]       phase;
    logic [CNT_W-1:0] dwell;
    logic             err;
    logic [2:0]       err_code;
    logic             cycle_done;
    logic [15:0]      cycle_cnt;
    logic             abort;

    traffic_light_monitor #(
        .RED_CYCLES(5), .GREEN_CYCLES(4), .YELLOW_CYCLES(2), .CNT_W(CNT_W)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_red(red), .i_yellow(yellow),
        .i_green(green), .i_clear(clr), .o_phase(phase), .o_dwell(dwell),
        .o_err(err), .o_err_code(err_code), .o_cycle_done(cycle_done),
        .o_cycle_cnt(cycle_cnt), .o_abort(abort)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: phases 0 idle, 1 red, 2 green, 3 yellow, 4 error.
    int expd[4] = '{0, 5, 4, 2};
    int m_ph = 0, m_dw = 0, m_code = 0, m_cnt = 0;
    bit m_err = 0, m_done = 0, m_abort = 0;

    task automatic model_step(input bit r_s, input bit r, input bit y,
                              input bit g, input bit c);
        int nl, col, cause, nxt;
        if (r_s) begin
            m_ph = 0; m_dw = 0; m_err = 0; m_code = 0;
            m_done = 0; m_cnt = 0; m_abort = 0;
            return;
        end
        m_done = 0; m_abort = 0; cause = 0;
        nl  = int'(r) + int'(y) + int'(g);
        col = (nl != 1) ? 0 : (r ? 1 : (g ? 2 : 3));
        if (c) begin
            m_ph = 0; m_dw = 0; m_err = 0; m_code = 0;
            return;
        end
        if (m_ph == 4) begin
`ifdef TLMON_AUTORECOVER_EN
            if (col == 1) begin m_ph = 1; m_dw = 1; end
`endif
        end else if (m_ph == 0) begin
            if (nl > 1)        cause = 1;
            else if (col == 0) m_dw = 0;
            else if (col == 1) begin m_ph = 1; m_dw = 1; end
            else               cause = 2;
        end else begin
            nxt = m_ph % 3 + 1;
            if (nl > 1) cause = 1;
            else if (col == 0) begin m_ph = 0; m_dw = 0; m_abort = 1; end
            else if (col == m_ph) begin
                if (m_dw >= expd[m_ph]) cause = 4; else m_dw++;
            end else if (col == nxt) begin
                if (m_dw < expd[m_ph]) cause = 3;
                else begin
                    if (m_ph == 3) begin
                        m_done = 1;
                        if (m_cnt < 65535) m_cnt++;
                    end
                    m_ph = nxt; m_dw = 1;
                end
            end else cause = 2;
        end
        if (cause != 0) begin
            if (!m_err) m_code = cause;
            m_err = 1; m_ph = 4;
        end
    endtask

    // Drive one sample, advance the model alongside the DUT, sample after edge.
    task automatic apply(input bit r_s, input bit r, input bit y, input bit g,
                         input bit c);
        @(negedge clk);
        rst = r_s; red = r; yellow = y; green = g; clr = c;
        @(posedge clk);
        model_step(r_s, r, y, g, c);
        #1;
    endtask

    task automatic compare(input string name, input int ph, input int dw,
                           input bit er, input int cd, input bit dn,
                           input int cn, input bit ab);
        vectors++;
        if (int'(phase) != ph || int'(dwell) != dw || err != er ||
            int'(err_code) != cd || cycle_done != dn || int'(cycle_cnt) != cn ||
            abort != ab) begin
            miscompares++;
            $display("FAIL %s: got ph=%0d dw=%0d err=%0b code=%0d done=%0b cnt=%0d abort=%0b, want ph=%0d dw=%0d err=%0b code=%0d done=%0b cnt=%0d abort=%0b",
                     name, phase, dwell, err, err_code, cycle_done, cycle_cnt,
                     abort, ph, dw, er, cd, dn, cn, ab);
        end
    endtask

    task automatic check_model(input string name);
        compare(name, m_ph, m_dw, m_err, m_code, m_done, m_cnt, m_abort);
    endtask

    typedef struct {
        bit rst, r, y, g, c;
        int ph, dw;
        bit er;
        int cd;
        bit dn;
        int cnt;
        bit ab;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rs, input bit r, input bit y, input bit g,
                       input bit c, input int ph, input int dw, input bit er,
                       input int cd, input bit dn, input int cnt, input bit ab);
        vec_t v;
        v.rst = rs; v.r = r; v.y = y; v.g = g; v.c = c;
        v.ph = ph; v.dw = dw; v.er = er; v.cd = cd; v.dn = dn;
        v.cnt = cnt; v.ab = ab;
        tbl.push_back(v);
    endtask

    // n samples of one colour (1 red, 2 green, 3 yellow), dwell counting up.
    task automatic add_run(input int col, input int n, input int cnt);
        for (int i = 1; i <= n; i++)
            add(0, col == 1, col == 3, col == 2, 0, col, i, 0, 0, 0, cnt, 0);
    endtask

    initial begin
        int pulses;
        int s_col, s_left;
        bit r, y, g, c, rs;

        // Reset, one legal cycle, then priority/clear/order/long/short/abort.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_run(1, 5, 0);
        add_run(2, 4, 0);
        add_run(3, 2, 0);
        add(0, 1, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0);
        add(0, 1, 0, 0, 0, 1, 2, 0, 0, 0, 1, 0);
        add(0, 1, 0, 1, 0, 4, 2, 1, 1, 0, 1, 0);
        add(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0, 4, 0, 1, 2, 0, 1, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        add_run(1, 5, 1);
        add(0, 1, 0, 0, 0, 4, 5, 1, 4, 0, 1, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        add_run(1, 5, 1);
        add_run(2, 3, 1);
        add(0, 0, 1, 0, 0, 4, 3, 1, 3, 0, 1, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        add_run(1, 5, 1);
        add_run(2, 4, 1);
        add_run(3, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].rst, tbl[i].r, tbl[i].y, tbl[i].g, tbl[i].c);
            compare($sformatf("table[%0d]", i), tbl[i].ph, tbl[i].dw, tbl[i].er,
                    tbl[i].cd, tbl[i].dn, tbl[i].cnt, tbl[i].ab);
        end

        // Three full legal cycles from IDLE; the 4th red completes the 3rd.
        apply(1, 0, 0, 0, 0);
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 5; i++) begin apply(0, 1, 0, 0, 0); check_model("legal_run"); pulses += int'(cycle_done); end
            for (int i = 0; i < 4; i++) begin apply(0, 0, 0, 1, 0); check_model("legal_run"); pulses += int'(cycle_done); end
            for (int i = 0; i < 2; i++) begin apply(0, 0, 1, 0, 0); check_model("legal_run"); pulses += int'(cycle_done); end
        end
        apply(0, 1, 0, 0, 0);
        pulses += int'(cycle_done);
        compare("three_cycles", 1, 1, 0, 0, 1, 3, 0);
        vectors++;
        if (pulses != 3) begin
            miscompares++;
            $display("FAIL done_pulses: got %0d, want 3", pulses);
        end

`ifdef TLMON_AUTORECOVER_EN
        // Error, then a legal red re-enters RED with the code kept sticky.
        apply(1, 0, 0, 0, 0);
        apply(0, 0, 0, 1, 0);
        compare("ar_order", 4, 0, 1, 2, 0, 0, 0);
        apply(0, 1, 0, 0, 0);
        compare("ar_recover", 1, 1, 1, 2, 0, 0, 0);
        apply(0, 1, 0, 0, 0);
        compare("ar_red2", 1, 2, 1, 2, 0, 0, 0);
        apply(0, 0, 0, 1, 0);
        compare("ar_short_keeps_code", 4, 2, 1, 2, 0, 0, 0);
`endif

        // Randomized traffic: mostly a scheduled legal sequence with perturbed
        // dwell, occasional random lamp patterns, clears and resets.
        apply(1, 0, 0, 0, 0);
        s_col = 3; s_left = 0;
        for (int n = 0; n < 3000; n++) begin
            if (s_left == 0) begin
                s_col  = s_col % 3 + 1;
                s_left = expd[s_col];
                if ($urandom_range(0, 4) == 0)
                    s_left = s_left + int'($urandom_range(0, 2)) - 1;
                if (s_left < 1) s_left = 1;
            end
            s_left--;
            r = (s_col == 1); g = (s_col == 2); y = (s_col == 3);
            if ($urandom_range(0, 19) == 0) {r, y, g} = 3'($urandom);
            c  = m_err ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
            rs = ($urandom_range(0, 199) == 0);
            apply(rs, r, y, g, c);
            check_model("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
